vga_contador: RTL and testbench
===============================

VGA_CONTADOR -- requirements
Module: vga_contador

Interface
REQ-001 SHALL have parameter H_VISIVEL, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_TOTAL, default 800, pixel periods per line.
REQ-003 SHALL have parameter V_VISIVEL, default 480, visible lines per frame.
REQ-004 SHALL have parameter V_TOTAL, default 525, lines per frame.
REQ-005 SHALL have port clk, input, 1, the single block clock; one clock domain only.
REQ-006 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-007 SHALL have port pixel_en, input, 1, pixel tick (one clk-wide pulse per pixel period).
REQ-008 SHALL have port x, output, 10, current horizontal pixel index; feeds the downstream <=640 comparator.
REQ-009 SHALL have port y, output, 10, current line index.
REQ-010 SHALL have port hsync, output, 1, horizontal sync, active-low.
REQ-011 SHALL have port vsync, output, 1, vertical sync, active-low.
REQ-012 SHALL have port video_on, output, 1, high only inside the visible area.
REQ-013 SHALL have port fim_linha, output, 1, one-clk pulse at end of line.
REQ-014 SHALL have port fim_quadro, output, 1, one-clk pulse at end of frame.

Function
REQ-015 SHALL hold x and y as registers; they change only on a clk rising edge with pixel_en=1.
REQ-016 SHALL, with pixel_en=0, hold x, y and all decoded outputs unchanged; fim_linha and fim_quadro SHALL be 0.
REQ-017 SHALL, with pixel_en=1 and x<H_TOTAL-1, increment x by 1 and leave y unchanged.
REQ-018 SHALL, with pixel_en=1 and x=H_TOTAL-1 (799), wrap x to 0 and increment y in the same edge.
REQ-019 SHALL, with pixel_en=1, x=799 and y=V_TOTAL-1 (524), wrap both x and y to 0 in the same edge.
REQ-020 SHALL assert fim_linha combinationally when pixel_en=1 and x=799.
REQ-021 SHALL assert fim_quadro combinationally when pixel_en=1, x=799 and y=524; fim_quadro implies fim_linha.
REQ-022 SHALL drive hsync=0 exactly for x in 656..751 (front porch 16, sync 96, back porch 48), else 1.
REQ-023 SHALL drive vsync=0 exactly for y in 490..491 (front porch 10, sync 2, back porch 33), else 1.
REQ-024 SHALL drive video_on=1 iff x<H_VISIVEL and y<V_VISIVEL.
REQ-025 SHALL decode hsync, vsync and video_on from the current x/y registers with zero cycles of latency.
REQ-026 SHALL never produce x>799 or y>524; any out-of-range value SHALL wrap to 0 on the next enabled edge.

Reset
REQ-027 SHALL, while rst=1, force x=0 and y=0 immediately, without waiting for clk.
REQ-028 SHALL, during reset, output hsync=1, vsync=1, video_on=1, fim_linha=0, fim_quadro=0.
REQ-029 SHALL, on reset mid-frame, abandon the frame; counting restarts at (0,0) on the first enabled edge after rst falls.

Structure
REQ-030 SHALL take all timing constants (640/16/96/48/800, 480/10/2/33/525, sync start/end) from shared package vga_pkg.
REQ-031 SHALL build x and y from two instances of sub-module contador_mod (mod-N counter with enable input and terminal-count output).
REQ-032 SHALL chain the counters: the x counter's terminal-count AND pixel_en SHALL enable the y counter.

Verification
REQ-033 SHALL check reset: assert rst mid-line at x=300, y=100 -> x=0, y=0, hsync=1, vsync=1 before the next clk edge.
REQ-034 SHALL check the line wrap: pixel_en=1 at x=799, y=10 -> next edge x=0, y=11, with fim_linha=1 in the cycle before the edge.
REQ-035 SHALL check the frame wrap: pixel_en=1 at x=799, y=524 -> next edge x=0, y=0, with fim_quadro=1 in the cycle before the edge.
REQ-036 SHALL check hsync: sweep x 0..799 -> hsync=0 exactly for x=656..751 (96 pixels); vsync=0 exactly for y=490..491.
REQ-037 SHALL check video_on: (639,479)->1, (640,0)->0, (0,480)->0.
REQ-038 SHALL check enable gating: pixel_en toggling 1/0 with 50 MHz clk -> one full frame takes exactly 800*525*2=840000 clk cycles, and counts are frozen whenever pixel_en=0.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants and small helpers.
// Sync windows are derived from visible size plus porch widths.
package vga_pkg;

  localparam int CW = 10;

  localparam int H_VIS   = 640;
  localparam int H_FRONT = 16;
  localparam int H_SYNC  = 96;
  localparam int H_BACK  = 48;
  localparam int H_TOT   = H_VIS + H_FRONT + H_SYNC + H_BACK;

  localparam int V_VIS   = 480;
  localparam int V_FRONT = 10;
  localparam int V_SYNC  = 2;
  localparam int V_BACK  = 33;
  localparam int V_TOT   = V_VIS + V_FRONT + V_SYNC + V_BACK;

  localparam int H_SYNC_START = H_VIS + H_FRONT;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int V_SYNC_START = V_VIS + V_FRONT;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  typedef logic [CW-1:0] coord_t;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic video_on;
  } timing_t;

  function automatic logic in_range(
    input coord_t v,
    input int     lo,
    input int     hi
  );
    return (int'(v) >= lo) && (int'(v) <= hi);
  endfunction

endpackage

// File: rtl/contador_mod.sv
// Mod-N counter with enable and terminal-count flag.
// Any value at or above N-1 counts as terminal, so strays wrap to 0.
module contador_mod #(
  parameter int N = 800,
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] q,
  output logic         tc
);

  assign tc = (q >= W'(N - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= tc ? '0 : q + W'(1);
    end
  end

endmodule

// File: rtl/vga_contador.sv
// VGA raster counter: chained x/y mod counters plus zero-latency
// sync, blanking and end-of-line/frame decode.
module vga_contador
  import vga_pkg::*;
#(
  parameter int H_VISIVEL = H_VIS,
  parameter int H_TOTAL   = H_TOT,
  parameter int V_VISIVEL = V_VIS,
  parameter int V_TOTAL   = V_TOT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pixel_en,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic          fim_linha,
  output logic          fim_quadro
);

  localparam int HS_START = H_VISIVEL + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC - 1;
  localparam int VS_START = V_VISIVEL + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC - 1;

  logic    x_tc;
  logic    y_tc;
  logic    y_en;
  timing_t dec;

  contador_mod #(
    .N(H_TOTAL),
    .W(CW)
  ) u_x (
    .clk(clk),
    .rst(rst),
    .en (pixel_en),
    .q  (x),
    .tc (x_tc)
  );

  assign y_en = pixel_en & x_tc;

  contador_mod #(
    .N(V_TOTAL),
    .W(CW)
  ) u_y (
    .clk(clk),
    .rst(rst),
    .en (y_en),
    .q  (y),
    .tc (y_tc)
  );

  always_comb begin
    dec          = '0;
    dec.hsync    = ~in_range(x, HS_START, HS_END);
    dec.vsync    = ~in_range(y, VS_START, VS_END);
    dec.video_on = (int'(x) < H_VISIVEL)
                 & (int'(y) < V_VISIVEL);
  end

  assign hsync      = dec.hsync;
  assign vsync      = dec.vsync;
  assign video_on   = dec.video_on;
  assign fim_linha  = y_en;
  assign fim_quadro = y_en & y_tc;

endmodule

// File: tb/tb_vga_contador.sv
// Bench for vga_contador: full-size and shrunk instances checked
// each cycle against a pixel-count model plus directed vectors.
module tb_vga_contador;

  localparam int BH_VIS = 16;
  localparam int BH_TOT = 176;
  localparam int BV_VIS = 8;
  localparam int BV_TOT = 53;

  logic       clk = 1'b0;
  logic       rst_a, rst_b, pe_a, pe_b;
  logic [9:0] xa, ya, xb, yb;
  logic       hs_a, vs_a, von_a, fl_a, fq_a;
  logic       hs_b, vs_b, von_b, fl_b, fq_b;

  int n_chk  = 0;
  int n_fail = 0;
  int na = 0;
  int nb = 0;

  always #10 clk = ~clk;

  vga_contador dut_a (
    .clk(clk), .rst(rst_a), .pixel_en(pe_a),
    .x(xa), .y(ya), .hsync(hs_a), .vsync(vs_a),
    .video_on(von_a), .fim_linha(fl_a),
    .fim_quadro(fq_a)
  );

  vga_contador #(
    .H_VISIVEL(BH_VIS), .H_TOTAL(BH_TOT),
    .V_VISIVEL(BV_VIS), .V_TOTAL(BV_TOT)
  ) dut_b (
    .clk(clk), .rst(rst_b), .pixel_en(pe_b),
    .x(xb), .y(yb), .hsync(hs_b), .vsync(vs_b),
    .video_on(von_b), .fim_linha(fl_b),
    .fim_quadro(fq_b)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s: got %0d expected %0d at %0t",
                 nm, act, exp, $time);
    end
  endtask

  // Model: a raster is just the count of enabled pixel ticks.
  always @(posedge clk or posedge rst_a)
    if (rst_a) na <= 0;
    else if (pe_a) na <= na + 1;

  always @(posedge clk or posedge rst_b)
    if (rst_b) nb <= 0;
    else if (pe_b) nb <= nb + 1;

  task automatic cmp(input string tag, input int n,
                     input int ht, input int vt,
                     input int hv, input int vv,
                     input logic pe, input logic [9:0] x,
                     input logic [9:0] y, input logic hs,
                     input logic vs, input logic von,
                     input logic fl, input logic fq);
    int ex, ey;
    logic ehs, evs, evon, efl, efq;
    ex   = n % ht;
    ey   = (n / ht) % vt;
    ehs  = !(ex >= hv + 16 && ex < hv + 16 + 96);
    evs  = !(ey >= vv + 10 && ey < vv + 10 + 2);
    evon = (ex < hv) && (ey < vv);
    efl  = pe && (ex == ht - 1);
    efq  = efl && (ey == vt - 1);
    chk({tag, ".x"}, 32'(x), ex);
    chk({tag, ".y"}, 32'(y), ey);
    chk({tag, ".hsync"}, 32'(hs), 32'(ehs));
    chk({tag, ".vsync"}, 32'(vs), 32'(evs));
    chk({tag, ".video_on"}, 32'(von), 32'(evon));
    chk({tag, ".fim_linha"}, 32'(fl), 32'(efl));
    chk({tag, ".fim_quadro"}, 32'(fq), 32'(efq));
  endtask

  always @(negedge clk) begin
    cmp("a", na, 800, 525, 640, 480, pe_a,
        xa, ya, hs_a, vs_a, von_a, fl_a, fq_a);
    cmp("b", nb, BH_TOT, BV_TOT, BH_VIS, BV_VIS, pe_b,
        xb, yb, hs_b, vs_b, von_b, fl_b, fq_b);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cyc, c1, cnt, first, last, fq_cnt, k;
    rst_a = 1'b1; rst_b = 1'b1;
    pe_a  = 1'b0; pe_b  = 1'b0;
    repeat (3) step();
    pe_a = 1'b1;
    step();
    chk("rst_x", 32'(xa), 0);
    chk("rst_y", 32'(ya), 0);
    chk("rst_hsync", 32'(hs_a), 1);
    chk("rst_vsync", 32'(vs_a), 1);
    chk("rst_video_on", 32'(von_a), 1);
    chk("rst_fim_linha", 32'(fl_a), 0);
    chk("rst_fim_quadro", 32'(fq_a), 0);
    rst_a = 1'b0; rst_b = 1'b0;

    // enable gating: half-rate ticks, 1600 clk per line
    cyc = 0; c1 = 0;
    pe_a = 1'b1;
    while (!(xa == 0 && ya == 2) && cyc < 5000) begin
      step();
      cyc++;
      if (xa == 0 && ya == 1 && c1 == 0) c1 = cyc;
      pe_a = ~pe_a;
    end
    chk("line1_clks", c1, 1599);
    chk("line_period", cyc - c1, 1600);
    pe_a = 1'b0;
    step();
    k = 32'(xa);
    repeat (5) step();
    chk("frozen_x", 32'(xa), k);
    chk("frozen_y", 32'(ya), 2);

    // hsync sweep of one whole line
    pe_a = 1'b1;
    cnt = 0; first = -1; last = -1;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if (!hs_a) begin
        cnt++;
        if (first < 0) first = 32'(xa);
        last = 32'(xa);
      end
      if (xa == 639) chk("von_639", 32'(von_a), 1);
      if (xa == 640) chk("von_640", 32'(von_a), 0);
      step();
    end
    chk("hs_low_cnt", cnt, 96);
    chk("hs_first", first, 656);
    chk("hs_last", last, 751);
    chk("sweep_end_y", 32'(ya), 3);

    // line wrap at y=10
    k = 0;
    while (!(xa == 799 && ya == 10) && k < 10000) begin
      step();
      k++;
    end
    chk("reach_799_10", 32'(xa == 799 && ya == 10), 1);
    @(negedge clk);
    chk("wrap_fim_linha", 32'(fl_a), 1);
    chk("wrap_fim_quadro", 32'(fq_a), 0);
    step();
    chk("wrap_x", 32'(xa), 0);
    chk("wrap_y", 32'(ya), 11);
    pe_a = 1'b0;

    // shrunk raster: one full frame
    pe_b = 1'b1;
    cnt = 0; first = -1; fq_cnt = 0;
    for (int i = 0; i < BH_TOT * BV_TOT; i++) begin
      @(negedge clk);
      if (!vs_b) begin
        cnt++;
        if (first < 0) first = 32'(yb);
      end
      if (xb == 15 && yb == 7) chk("von_15_7", 32'(von_b), 1);
      if (xb == 16 && yb == 0) chk("von_16_0", 32'(von_b), 0);
      if (xb == 0 && yb == 8) chk("von_0_8", 32'(von_b), 0);
      if (fq_b) begin
        fq_cnt++;
        chk("fq_at_x", 32'(xb), BH_TOT - 1);
        chk("fq_at_y", 32'(yb), BV_TOT - 1);
        chk("fq_implies_fl", 32'(fl_b), 1);
      end
      step();
    end
    chk("vs_low_cnt", cnt, 2 * BH_TOT);
    chk("vs_first_y", first, 18);
    chk("fq_count", fq_cnt, 1);
    chk("frame_wrap_x", 32'(xb), 0);
    chk("frame_wrap_y", 32'(yb), 0);

    // asynchronous reset mid-line
    k = 0;
    while (!(xb == 100 && yb == 20) && k < 10000) begin
      step();
      k++;
    end
    chk("reach_100_20", 32'(xb == 100 && yb == 20), 1);
    rst_b = 1'b1;
    #1;
    chk("arst_x", 32'(xb), 0);
    chk("arst_y", 32'(yb), 0);
    chk("arst_hsync", 32'(hs_b), 1);
    chk("arst_vsync", 32'(vs_b), 1);
    repeat (2) step();
    rst_b = 1'b0;
    step();
    chk("restart_x", 32'(xb), 1);
    chk("restart_y", 32'(yb), 0);
    pe_b = 1'b0;
    repeat (2) step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
